// File: rtl/tcam_loader.sv
// Streams key/mask/destination entries into a TCAM after a flush, sequencing
// the TCAM strobes and gating lookups until the table is complete.
module tcam_loader #(
  parameter int ID_Width    = 4,
  parameter int AddressSize = 4,
  parameter int Bits        = 8,
  parameter int Words       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_start,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ID_Width-1:0]    cfg_key,
  input  logic [ID_Width-1:0]    cfg_mask,
  input  logic [ID_Width-1:0]    cfg_dst_id,
  input  logic                   cfg_last,
  output logic                   CS,
  output logic                   FLUSH,
  output logic                   VBE,
  output logic                   DCS,
  output logic                   WR,
  output logic                   VBI,
  output logic [Bits-1:0]        Data_In,
  output logic [Bits-1:0]        Mask_In,
  output logic [AddressSize-1:0] Addr_In,
  output logic                   lookup_en,
  output logic [AddressSize:0]   entry_count,
  output logic                   err_overflow
);

  localparam int CW = AddressSize + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SETTLE = 3'd2,
    S_LOAD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state;
  logic   handshake;
  logic   last_beat;

  assign handshake = cfg_valid && cfg_ready;
  // The handshake that fills the final slot ends the load even without cfg_last.
  assign last_beat = cfg_last || (entry_count == CW'(Words - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cfg_ready    <= 1'b0;
      CS           <= 1'b0;
      FLUSH        <= 1'b0;
      VBE          <= 1'b0;
      DCS          <= 1'b0;
      WR           <= 1'b0;
      VBI          <= 1'b0;
      Data_In      <= {Bits{1'b0}};
      Mask_In      <= {Bits{1'b0}};
      Addr_In      <= {AddressSize{1'b0}};
      lookup_en    <= 1'b0;
      entry_count  <= {CW{1'b0}};
      err_overflow <= 1'b0;
    end else begin
      FLUSH <= 1'b0;
      VBE   <= 1'b0;
      DCS   <= 1'b0;
      WR    <= 1'b0;
      VBI   <= 1'b0;
      // load_start wins over everything, including a coincident handshake.
      if (load_start) begin
        state        <= S_FLUSH;
        FLUSH        <= 1'b1;
        CS           <= 1'b1;
        cfg_ready    <= 1'b0;
        entry_count  <= {CW{1'b0}};
        lookup_en    <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            CS        <= 1'b0;
            cfg_ready <= 1'b0;
          end
          S_FLUSH: begin
            state <= S_SETTLE;
            CS    <= 1'b0;
          end
          S_SETTLE: begin
            state     <= S_LOAD;
            CS        <= 1'b1;
            cfg_ready <= 1'b1;
          end
          S_LOAD: begin
            CS <= 1'b1;
            if (handshake) begin
              WR          <= 1'b1;
              VBE         <= 1'b1;
              VBI         <= 1'b1;
              DCS         <= 1'b1;
              Data_In     <= {cfg_key, cfg_dst_id};
              Mask_In     <= {cfg_mask, {ID_Width{1'b1}}};
              Addr_In     <= entry_count[AddressSize-1:0];
              entry_count <= entry_count + {{AddressSize{1'b0}}, 1'b1};
              if (last_beat) begin
                state     <= S_DONE;
                cfg_ready <= 1'b0;
              end else begin
                state     <= S_LOAD;
                cfg_ready <= 1'b1;
              end
            end else begin
              state     <= S_LOAD;
              cfg_ready <= 1'b1;
            end
          end
          S_DONE: begin
            CS        <= 1'b1;
            cfg_ready <= 1'b0;
            lookup_en <= 1'b1;
            if (cfg_valid) begin
              err_overflow <= 1'b1;
            end else begin
              err_overflow <= err_overflow;
            end
          end
          default: begin
            state     <= S_IDLE;
            CS        <= 1'b0;
            cfg_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tcam_loader.sv
// Directed self-checking bench for tcam_loader with hand-computed expectations.
module tb_tcam_loader;

  logic       clk;
  logic       rst_n;
  logic       load_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_key;
  logic [3:0] cfg_mask;
  logic [3:0] cfg_dst_id;
  logic       cfg_last;
  logic       CS, FLUSH, VBE, DCS, WR, VBI;
  logic [7:0] Data_In, Mask_In;
  logic [3:0] Addr_In;
  logic       lookup_en;
  logic [4:0] entry_count;
  logic       err_overflow;

  int checks = 0;
  int errors = 0;

  tcam_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key),
    .cfg_mask(cfg_mask), .cfg_dst_id(cfg_dst_id), .cfg_last(cfg_last),
    .CS(CS), .FLUSH(FLUSH), .VBE(VBE), .DCS(DCS), .WR(WR), .VBI(VBI),
    .Data_In(Data_In), .Mask_In(Mask_In), .Addr_In(Addr_In),
    .lookup_en(lookup_en), .entry_count(entry_count), .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] k, input logic [3:0] m, input logic [3:0] d, input logic l);
    cfg_valid = 1'b1; cfg_key = k; cfg_mask = m; cfg_dst_id = d; cfg_last = l;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; cfg_key = 4'h0; cfg_mask = 4'h0; cfg_dst_id = 4'h0; cfg_last = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {26'd0, CS, FLUSH, VBE, DCS, WR, VBI}, 32'd0);
    check({tag, "_ready"}, {31'd0, cfg_ready}, 32'd0);
    check({tag, "_data"}, {16'd0, Data_In, Mask_In}, 32'd0);
    check({tag, "_addr"}, {28'd0, Addr_In}, 32'd0);
    check({tag, "_count"}, {27'd0, entry_count}, 32'd0);
    check({tag, "_flags"}, {30'd0, lookup_en, err_overflow}, 32'd0);
  endtask

  // Flush and settle; leaves the bench in the first LOAD cycle.
  task automatic start_load(input string tag);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check({tag, "_flush"}, {30'd0, FLUSH, CS}, 32'd3);
    check({tag, "_flush_clr"}, {25'd0, entry_count, lookup_en, err_overflow}, 32'd0);
    step();
    check({tag, "_settle"}, {26'd0, CS, FLUSH, VBE, DCS, WR, VBI, cfg_ready}, 32'd0);
    step();
    check({tag, "_ready"}, {30'd0, cfg_ready, WR}, 32'd2);
  endtask

  initial begin
    logic [3:0] k;
    rst_n = 1'b0; load_start = 1'b0;
    idle_inputs();
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check({31'd0, CS}, 32'd0, 32'd0);
    check("idle_cs_ready", {30'd0, CS, cfg_ready}, 32'd0);

    // Full load of 16 back-to-back beats.
    start_load("full");
    for (int i = 0; i < 16; i++) begin
      k = i[3:0];
      beat(k, k, ~k, 1'b0);
      step();
      check("full_wr", {27'd0, WR, VBE, VBI, DCS, CS}, 32'h1F);
      check("full_addr", {28'd0, Addr_In}, {28'd0, k});
      check("full_data", {16'd0, Data_In, Mask_In}, {16'd0, k, ~k, k, 4'hF});
      check("full_count", {27'd0, entry_count}, i + 1);
      check("full_ready", {31'd0, cfg_ready}, (i < 15) ? 32'd1 : 32'd0);
      check("full_lookup_early", {31'd0, lookup_en}, 32'd0);
    end
    idle_inputs();
    step();
    check("full_done", {28'd0, WR, CS, lookup_en, cfg_ready}, 32'b0110);
    check("full_count_end", {27'd0, entry_count}, 32'd16);

    // Overflow in DONE.
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("ovf_set", {30'd0, err_overflow, WR}, 32'b10);
    step();
    check("ovf_sticky", {30'd0, err_overflow, WR}, 32'b10);

    // Short load ending on cfg_last.
    start_load("short");
    beat(4'h1, 4'h2, 4'h3, 1'b0);
    step();
    check("short0", {19'd0, WR, Addr_In, Data_In}, {19'd0, 1'b1, 4'h0, 8'h13});
    beat(4'hA, 4'hF, 4'h3, 1'b0);
    step();
    check("short1", {3'd0, WR, Addr_In, Data_In, Mask_In, 8'd0}, {3'd0, 1'b1, 4'h1, 8'hA3, 8'hFF, 8'd0});
    beat(4'h5, 4'h0, 4'h6, 1'b1);
    step();
    idle_inputs();
    check("short2", {18'd0, WR, cfg_ready, Addr_In, Mask_In}, {18'd0, 1'b1, 1'b0, 4'h2, 8'h0F});
    check("short_count", {27'd0, entry_count}, 32'd3);
    step();
    check("short_done", {29'd0, WR, CS, lookup_en}, 32'b011);

    // Gapped stream: valid 1,0,0,1.
    start_load("gap");
    beat(4'h2, 4'h0, 4'h0, 1'b0);
    step();
    idle_inputs();
    check("gap_wr0", {27'd0, WR, Addr_In}, {27'd0, 1'b1, 4'h0});
    step();
    check("gap_idle1", {31'd0, WR}, 32'd0);
    step();
    check("gap_idle2", {31'd0, WR}, 32'd0);
    beat(4'h3, 4'h0, 4'h0, 1'b0);
    step();
    idle_inputs();
    check("gap_wr1", {27'd0, WR, Addr_In}, {27'd0, 1'b1, 4'h1});
    step();
    check("gap_after", {31'd0, WR}, 32'd0);

    // Abort after 5 handshakes, with load_start coinciding with a beat.
    start_load("abort");
    for (int i = 0; i < 5; i++) begin
      k = i[3:0] + 4'h8;
      beat(k, 4'h0, 4'h0, 1'b0);
      step();
    end
    check("abort_pre", {27'd0, entry_count}, 32'd5);
    beat(4'hE, 4'h0, 4'h0, 1'b0);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    idle_inputs();
    check("abort_flush", {25'd0, FLUSH, WR, entry_count}, {25'd0, 1'b1, 1'b0, 5'd0});
    step();
    step();
    check("abort_reload_ready", {31'd0, cfg_ready}, 32'd1);
    beat(4'h7, 4'h1, 4'h2, 1'b0);
    step();
    check("abort_restart", {27'd0, WR, Addr_In}, {27'd0, 1'b1, 4'h0});

    // Reset applied in a handshake cycle.
    beat(4'h9, 4'h9, 4'h9, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_inputs();
    check_all_zero("rst_load");
    step();
    check("rst_idle", {29'd0, WR, CS, cfg_ready}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcam_loader.md
TCAM_LOADER -- requirements
Module: tcam_loader

Interface
REQ-001 SHALL have parameter ID_Width, default 4, the width of the packet key and of the destination ID.
REQ-002 SHALL have parameter AddressSize, default 4, the TCAM address width.
REQ-003 SHALL have parameter Bits, default 8, the TCAM word width, equal to 2*ID_Width.
REQ-004 SHALL have parameter Words, default 16, the number of TCAM entries.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port load_start, input, 1 bit: single-cycle request to flush and reload the table.
REQ-008 SHALL have ports cfg_valid (input, 1), cfg_ready (output, 1), cfg_key (input, ID_Width), cfg_mask (input, ID_Width), cfg_dst_id (input, ID_Width) and cfg_last (input, 1), forming the entry stream.
REQ-009 SHALL have TCAM-side outputs CS, FLUSH, VBE, DCS, WR, VBI (each 1 bit), Data_In and Mask_In (each Bits wide), and Addr_In (AddressSize wide).
REQ-010 SHALL have outputs lookup_en (1 bit: table valid, lookups allowed), entry_count (AddressSize+1 bits: entries written), and err_overflow (1 bit: sticky).

Function
REQ-011 SHALL implement states IDLE, FLUSH, SETTLE, LOAD and DONE.
REQ-012 SHALL move from IDLE or DONE to FLUSH on load_start=1; a load_start that arrives in FLUSH, SETTLE or LOAD SHALL abort the load and re-enter FLUSH.
REQ-013 SHALL hold FLUSH for exactly 1 cycle with outputs FLUSH=1 and CS=1, clear entry_count to 0, clear lookup_en and clear err_overflow, then go to SETTLE.
REQ-014 SHALL hold SETTLE for exactly 1 cycle with all TCAM strobes at 0, then go to LOAD.
REQ-015 SHALL drive cfg_ready=1 only in LOAD; a handshake is cfg_valid and cfg_ready both 1 on the same posedge.
REQ-016 SHALL, in the cycle after each handshake, drive WR=1, VBE=1, VBI=1, DCS=1 and CS=1.
REQ-017 SHALL, in that same WR cycle, drive Data_In={cfg_key, cfg_dst_id}, Mask_In={cfg_mask, all-ones(ID_Width)} and Addr_In=entry_count[AddressSize-1:0], all registered from the handshake.
REQ-018 SHALL increment entry_count by 1 per handshake, so back-to-back writes run at 1 per cycle.
REQ-019 SHALL go from LOAD to DONE on the handshake that has cfg_last=1 or that makes entry_count equal Words.
REQ-020 SHALL drive WR=0 in every cycle that does not directly follow a handshake; WR is a 1-cycle pulse per entry.
REQ-021 SHALL, in DONE, drive CS=1 and all other strobes 0, and assert lookup_en starting one cycle after the final WR cycle.
REQ-022 SHALL set err_overflow when cfg_valid=1 in DONE and no load_start is present in the same cycle; err_overflow stays set until the next FLUSH or reset, and the offending beat is not written.
REQ-023 SHALL, in IDLE, drive CS=0, cfg_ready=0 and lookup_en=0.
REQ-024 SHALL, when load_start and a handshake coincide in LOAD, honour load_start: the beat is dropped and no WR is issued for it.

Reset
REQ-025 SHALL, on rst_n=0 at a posedge, go to IDLE and zero all outputs, including Data_In, Mask_In, Addr_In, entry_count, lookup_en and err_overflow.
REQ-026 SHALL, on reset during LOAD, issue no further WR, including any write pending from a handshake in the reset cycle.

Verification
REQ-027 Full load: load_start, then 16 back-to-back beats with keys 0..15 -> FLUSH pulse 1 cycle, 1 SETTLE cycle, WR on 16 consecutive cycles at Addr_In 0..15, entry_count=16, lookup_en=1 one cycle after the last WR.
REQ-028 Short load: 3 beats with the third carrying cfg_last; beat 2 has cfg_key=4'hA, cfg_mask=4'hF, cfg_dst_id=4'h3 -> its WR shows Data_In=8'hA3, Mask_In=8'hFF, Addr_In=1; DONE follows with entry_count=3.
REQ-029 Gapped stream: cfg_valid toggled 1,0,0,1 -> a WR only in the cycle after each handshake, and Addr_In increments 0 then 1.
REQ-030 Overflow: cfg_valid=1 held in DONE -> err_overflow=1 with no WR; a following load_start clears it during FLUSH.
REQ-031 Abort: load_start asserted after 5 handshakes in LOAD -> FLUSH=1 the next cycle, entry_count=0, and the subsequent load restarts at Addr_In=0.
REQ-032 Reset during LOAD, applied in a handshake cycle -> no WR the next cycle, state IDLE, all outputs 0.
